// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the motor PWM command path.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    SRC_FAILSAFE = 2'd0,
    SRC_HOST     = 2'd1,
    SRC_RC       = 2'd2
  } source_t;

  localparam int         TICKS_PER_MS  = 255;
  localparam logic [7:0] NEUTRAL_WIDTH = 8'd127;
  localparam int         WD_BITS       = 17;

endpackage

// File: rtl/pwm_slew_limiter.sv
// Per-channel width register. With SLEW_LIMIT_EN defined the width walks toward
// its target by at most STEP per shared tick and snaps to neutral on pause;
// without it the width simply registers the target every cycle.
module pwm_slew_limiter
  import pwm_ctrl_pkg::*;
#(
  parameter int         STEP    = 4,
  parameter logic [7:0] NEUTRAL = NEUTRAL_WIDTH
) (
  input  logic       clk_255kHz,
  input  logic       reset,
  input  logic [7:0] target,
  input  logic       tick,
  input  logic       snap,
  output logic [7:0] width
);

`ifdef SLEW_LIMIT_EN
  localparam logic signed [8:0] STEP_POS = 9'(STEP);

  logic signed [8:0] diff;
  logic signed [9:0] moved;
  logic [7:0]        next_width;

  // One slew step toward the target, clamped so the width can never wrap
  always_comb begin
    diff = $signed({1'b0, target}) - $signed({1'b0, width});
    if (diff > STEP_POS) begin
      moved = $signed({2'b00, width}) + $signed({STEP_POS[8], STEP_POS});
    end else if (diff < -STEP_POS) begin
      moved = $signed({2'b00, width}) - $signed({STEP_POS[8], STEP_POS});
    end else begin
      moved = $signed({2'b00, target});
    end
    if (moved < 10'sd0) begin
      next_width = 8'd0;
    end else if (moved > 10'sd255) begin
      next_width = 8'd255;
    end else begin
      next_width = moved[7:0];
    end
  end

  // Pause snaps straight to neutral; otherwise the width only moves on a tick
  always_ff @(posedge clk_255kHz or negedge reset) begin
    if (!reset) begin
      width <= NEUTRAL;
    end else if (snap) begin
      width <= NEUTRAL;
    end else if (tick) begin
      width <= next_width;
    end
  end
`else
  localparam int step_unused = STEP;

  logic unused_inputs;
  assign unused_inputs = tick ^ snap;

  // Without slew limiting the width follows the target one cycle later
  always_ff @(posedge clk_255kHz or negedge reset) begin
    if (!reset) begin
      width <= NEUTRAL;
    end else begin
      width <= target;
    end
  end
`endif

endmodule

// File: rtl/pwm_command_arbiter.sv
// Chooses between host, RC and failsafe commands for the two motor PWM
// generators, with a host watchdog. Optional slew limiting: SLEW_LIMIT_EN.
module pwm_command_arbiter
  import pwm_ctrl_pkg::*;
#(
  parameter int         HOST_TIMEOUT_MS = 250,
  parameter int         SLEW_STEP       = 4,
  parameter int         SLEW_PERIOD     = 1275,
  parameter logic [7:0] NEUTRAL         = NEUTRAL_WIDTH
) (
  input  logic       clk_255kHz,
  input  logic       reset,
  input  logic [7:0] host_left,
  input  logic [7:0] host_right,
  input  logic       host_strobe,
  input  logic       rc_valid,
  input  logic [7:0] rc_left,
  input  logic [7:0] rc_right,
  input  logic       rc_override,
  input  logic       pause,
  output logic [7:0] width_left,
  output logic [7:0] width_right,
  output logic [1:0] source,
  output logic       host_timeout
);

  localparam logic [WD_BITS-1:0] LIMIT = WD_BITS'(HOST_TIMEOUT_MS * TICKS_PER_MS);

  logic [7:0]         host_l;
  logic [7:0]         host_r;
  logic [WD_BITS-1:0] wd_count;
  logic [WD_BITS-1:0] wd_next;
  source_t            state;
  logic [7:0]         target_l;
  logic [7:0]         target_r;
  logic               tick;

  assign source = state;

  // Watchdog advance: a strobe restarts it, otherwise count up and stick at the limit
  always_comb begin
    if (host_strobe) begin
      wd_next = '0;
    end else if (wd_count == LIMIT) begin
      wd_next = LIMIT;
    end else begin
      wd_next = wd_count + 1'b1;
    end
  end

  // Host command latches, watchdog count and its registered expiry flag
  always_ff @(posedge clk_255kHz or negedge reset) begin
    if (!reset) begin
      host_l       <= NEUTRAL;
      host_r       <= NEUTRAL;
      wd_count     <= LIMIT;
      host_timeout <= 1'b1;
    end else begin
      if (host_strobe) begin
        host_l <= host_left;
        host_r <= host_right;
      end
      wd_count     <= wd_next;
      host_timeout <= (wd_next == LIMIT);
    end
  end

  // Source selection: pause, then RC override, then a live host, else failsafe
  always_ff @(posedge clk_255kHz or negedge reset) begin
    if (!reset) begin
      state <= SRC_FAILSAFE;
    end else if (pause) begin
      state <= SRC_FAILSAFE;
    end else if (rc_valid && rc_override) begin
      state <= SRC_RC;
    end else if (!host_timeout) begin
      state <= SRC_HOST;
    end else begin
      state <= SRC_FAILSAFE;
    end
  end

  // Target widths follow the current source; RC values are used live
  always_comb begin
    target_l = NEUTRAL;
    target_r = NEUTRAL;
    case (state)
      SRC_HOST: begin
        target_l = host_l;
        target_r = host_r;
      end
      SRC_RC: begin
        target_l = rc_left;
        target_r = rc_right;
      end
      default: begin
        target_l = NEUTRAL;
        target_r = NEUTRAL;
      end
    endcase
  end

`ifdef SLEW_LIMIT_EN
  localparam int TICK_BITS = (SLEW_PERIOD > 1) ? $clog2(SLEW_PERIOD) : 1;

  logic [TICK_BITS-1:0] tick_count;

  assign tick = (tick_count == TICK_BITS'(SLEW_PERIOD - 1));

  // Free-running slew tick counter shared by both channels
  always_ff @(posedge clk_255kHz or negedge reset) begin
    if (!reset) begin
      tick_count <= '0;
    end else if (tick) begin
      tick_count <= '0;
    end else begin
      tick_count <= tick_count + 1'b1;
    end
  end
`else
  localparam int slew_cfg_unused = SLEW_PERIOD;

  assign tick = 1'b0;
`endif

  pwm_slew_limiter #(
    .STEP    (SLEW_STEP),
    .NEUTRAL (NEUTRAL)
  ) u_slew_left (
    .clk_255kHz (clk_255kHz),
    .reset      (reset),
    .target     (target_l),
    .tick       (tick),
    .snap       (pause),
    .width      (width_left)
  );

  pwm_slew_limiter #(
    .STEP    (SLEW_STEP),
    .NEUTRAL (NEUTRAL)
  ) u_slew_right (
    .clk_255kHz (clk_255kHz),
    .reset      (reset),
    .target     (target_r),
    .tick       (tick),
    .snap       (pause),
    .width      (width_right)
  );

endmodule

// File: tb/tb_pwm_command_arbiter.sv
// Bench for pwm_command_arbiter. Watchdog and slew period are shortened through
// the parameters so every scenario fits in a few thousand cycles; the reference
// model follows SLEW_LIMIT_EN the same way the design does.
module tb_pwm_command_arbiter;

  localparam int TB_TIMEOUT_MS = 4;
  localparam int TB_STEP       = 4;
  localparam int TB_PERIOD     = 8;
  localparam int TB_NEUTRAL    = 127;
  localparam int TB_LIMIT      = TB_TIMEOUT_MS * 255;

  logic       clk_255kHz = 1'b0;
  logic       reset;
  logic [7:0] host_left;
  logic [7:0] host_right;
  logic       host_strobe;
  logic       rc_valid;
  logic [7:0] rc_left;
  logic [7:0] rc_right;
  logic       rc_override;
  logic       pause;
  logic [7:0] width_left;
  logic [7:0] width_right;
  logic [1:0] source;
  logic       host_timeout;

  int errors = 0;
  int checks = 0;

  // Reference model state: plain integers
  int m_src;
  int m_hl;
  int m_hr;
  int m_since;
  int m_to;
  int m_phase;
  int m_wl;
  int m_wr;

  pwm_command_arbiter #(
    .HOST_TIMEOUT_MS (TB_TIMEOUT_MS),
    .SLEW_STEP       (TB_STEP),
    .SLEW_PERIOD     (TB_PERIOD),
    .NEUTRAL         (8'(TB_NEUTRAL))
  ) dut (
    .clk_255kHz   (clk_255kHz),
    .reset        (reset),
    .host_left    (host_left),
    .host_right   (host_right),
    .host_strobe  (host_strobe),
    .rc_valid     (rc_valid),
    .rc_left      (rc_left),
    .rc_right     (rc_right),
    .rc_override  (rc_override),
    .pause        (pause),
    .width_left   (width_left),
    .width_right  (width_right),
    .source       (source),
    .host_timeout (host_timeout)
  );

  always #5 clk_255kHz = ~clk_255kHz;

  function automatic int moveToward(input int cur, input int tgt);
    if (tgt > cur) return cur + ((tgt - cur) < TB_STEP ? (tgt - cur) : TB_STEP);
    return cur - ((cur - tgt) < TB_STEP ? (cur - tgt) : TB_STEP);
  endfunction

  task automatic modelReset();
    m_src   = 0;
    m_hl    = TB_NEUTRAL;
    m_hr    = TB_NEUTRAL;
    m_since = TB_LIMIT;
    m_to    = 1;
    m_phase = 0;
    m_wl    = TB_NEUTRAL;
    m_wr    = TB_NEUTRAL;
  endtask

  // Advance the model by one clock edge using the inputs present before it
  task automatic modelStep();
    int tl;
    int tr;
    tl = TB_NEUTRAL;
    tr = TB_NEUTRAL;
    if (m_src == 1) begin
      tl = m_hl;
      tr = m_hr;
    end else if (m_src == 2) begin
      tl = int'(rc_left);
      tr = int'(rc_right);
    end
`ifdef SLEW_LIMIT_EN
    if (pause) begin
      m_wl = TB_NEUTRAL;
      m_wr = TB_NEUTRAL;
    end else if (m_phase == TB_PERIOD - 1) begin
      m_wl = moveToward(m_wl, tl);
      m_wr = moveToward(m_wr, tr);
    end
`else
    m_wl = tl;
    m_wr = tr;
`endif
    if (pause) m_src = 0;
    else if (rc_valid && rc_override) m_src = 2;
    else if (m_to == 0) m_src = 1;
    else m_src = 0;
    if (host_strobe) begin
      m_hl = int'(host_left);
      m_hr = int'(host_right);
      m_since = 0;
    end else if (m_since < TB_LIMIT) begin
      m_since = m_since + 1;
    end
    m_to = (m_since == TB_LIMIT) ? 1 : 0;
    m_phase = (m_phase + 1) % TB_PERIOD;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".width_left"}, 32'(width_left), 32'(m_wl));
    checkValue({tag, ".width_right"}, 32'(width_right), 32'(m_wr));
    checkValue({tag, ".source"}, 32'(source), 32'(m_src));
    checkValue({tag, ".host_timeout"}, 32'(host_timeout), 32'(m_to));
  endtask

  // Run n cycles with the current inputs; strobe lasts only the first cycle
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_255kHz);
      modelStep();
      @(negedge clk_255kHz);
      host_strobe = 1'b0;
      checkOutput("cycle");
    end
  endtask

  task automatic hostCommand(input int l, input int r);
    host_left   = 8'(l);
    host_right  = 8'(r);
    host_strobe = 1'b1;
  endtask

  initial begin
    int rise_at;
    reset       = 1'b0;
    host_left   = 8'd0;
    host_right  = 8'd0;
    host_strobe = 1'b0;
    rc_valid    = 1'b0;
    rc_left     = 8'd0;
    rc_right    = 8'd0;
    rc_override = 1'b0;
    pause       = 1'b0;
    modelReset();

    $display("[TB] reset state");
    @(negedge clk_255kHz);
    @(negedge clk_255kHz);
    checkValue("rst.width_left", 32'(width_left), 32'd127);
    checkValue("rst.width_right", 32'(width_right), 32'd127);
    checkValue("rst.source", 32'(source), 32'd0);
    checkValue("rst.host_timeout", 32'(host_timeout), 32'd1);
    reset = 1'b1;

    $display("[TB] idle after reset");
    applyStimulus(2 * TB_LIMIT + 20);
    checkValue("idle.width_left", 32'(width_left), 32'd127);
    checkValue("idle.source", 32'(source), 32'd0);
    checkValue("idle.host_timeout", 32'(host_timeout), 32'd1);

    $display("[TB] host command");
    hostCommand(200, 50);
    applyStimulus(1);
    applyStimulus(1);
    checkValue("host.source", 32'(source), 32'd1);
    applyStimulus(25 * TB_PERIOD);
    checkValue("host.left_final", 32'(width_left), 32'd200);
    checkValue("host.right_final", 32'(width_right), 32'd50);

    $display("[TB] host watchdog");
    hostCommand(200, 50);
    applyStimulus(1);
    rise_at = -1;
    for (int k = 1; k <= TB_LIMIT + 5 && rise_at < 0; k++) begin
      applyStimulus(1);
      if (host_timeout === 1'b1) rise_at = k;
    end
    checkValue("wd.rise_cycle", 32'(rise_at), 32'(TB_LIMIT));
    applyStimulus(30 * TB_PERIOD);
    checkValue("wd.source", 32'(source), 32'd0);
    checkValue("wd.width_left", 32'(width_left), 32'd127);
    checkValue("wd.width_right", 32'(width_right), 32'd127);
    hostCommand(90, 160);
    applyStimulus(1);
    applyStimulus(TB_LIMIT - 1);
    checkValue("wd.before_expiry", 32'(host_timeout), 32'd0);
    hostCommand(90, 160);
    applyStimulus(1);
    checkValue("wd.strobe_at_expiry", 32'(host_timeout), 32'd0);
    applyStimulus(TB_LIMIT);
    checkValue("wd.expired", 32'(host_timeout), 32'd1);
    hostCommand(90, 160);
    applyStimulus(1);
    checkValue("wd.strobe_revives", 32'(host_timeout), 32'd0);

    $display("[TB] rc override");
    hostCommand(200, 50);
    applyStimulus(25 * TB_PERIOD);
    rc_valid    = 1'b1;
    rc_override = 1'b1;
    rc_left     = 8'd10;
    rc_right    = 8'($urandom_range(0, 255));
    applyStimulus(1);
    checkValue("rc.source", 32'(source), 32'd2);
    applyStimulus(10 * TB_PERIOD);
`ifdef SLEW_LIMIT_EN
    checkValue("rc.left_sliding_down", 32'(width_left < 8'd200 && width_left > 8'd10), 32'd1);
`else
    checkValue("rc.left_direct", 32'(width_left), 32'd10);
`endif
    rc_valid = 1'b0;
    applyStimulus(1);
    checkValue("rc.back_to_host", 32'(source), 32'd1);

    $display("[TB] pause");
    hostCommand(250, 30);
    applyStimulus(1);
    for (int k = 0; k < 40 * TB_PERIOD && width_left < 8'd240; k++) applyStimulus(1);
    checkValue("pause.reached_240", 32'(width_left >= 8'd240), 32'd1);
    pause = 1'b1;
    applyStimulus(1);
`ifndef SLEW_LIMIT_EN
    applyStimulus(1);
`endif
    checkValue("pause.width_left", 32'(width_left), 32'd127);
    checkValue("pause.width_right", 32'(width_right), 32'd127);
    checkValue("pause.source", 32'(source), 32'd0);
    pause = 1'b0;
    applyStimulus(40 * TB_PERIOD);
    checkValue("pause.resume_left", 32'(width_left), 32'd250);
    checkValue("pause.resume_right", 32'(width_right), 32'd30);

    $display("[TB] reset mid-slew");
    hostCommand(0, 255);
    applyStimulus(3 * TB_PERIOD + 3);
    #2;
    reset = 1'b0;
    #1;
    checkValue("midrst.width_left", 32'(width_left), 32'd127);
    checkValue("midrst.width_right", 32'(width_right), 32'd127);
    checkValue("midrst.source", 32'(source), 32'd0);
    checkValue("midrst.host_timeout", 32'(host_timeout), 32'd1);
    modelReset();
    @(negedge clk_255kHz);
    reset = 1'b1;
    hostCommand(200, 60);
    applyStimulus(TB_PERIOD - 1);
`ifdef SLEW_LIMIT_EN
    checkValue("midrst.before_first_tick", 32'(width_left), 32'd127);
    applyStimulus(1);
    checkValue("midrst.first_tick", 32'(width_left), 32'd131);
`else
    checkValue("midrst.direct", 32'(width_left), 32'd200);
`endif

    $display("[TB] randomized traffic");
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, (k < 700) ? 15 : 400) == 0) begin
        hostCommand(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end
      rc_left  = 8'($urandom_range(0, 255));
      rc_right = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) rc_valid = ~rc_valid;
      if ($urandom_range(0, 11) == 0) rc_override = ~rc_override;
      if ($urandom_range(0, 39) == 0) pause = ~pause;
      applyStimulus(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
